rf_writeback_arb: RTL and testbench

//  Write-side front end of the 32x32 register file. Merges two result sources onto the single RF write port:
//  - the in-order pipeline writeback (always accepted)
//  - late results from the multi-cycle mult/div unit (valid/ready handshake, buffered in a small FIFO)

---
 rtl/rf_writeback_arb.sv | 142 ++++++++++++++
 tb/tb_rf_writeback_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arb.sv
// Register-file write-port arbiter: pipeline writeback wins, buffered mult/div
// results fill idle slots, and a busy scoreboard tracks pending destinations.
module rf_writeback_arb #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic              md_issue,
    input  logic [ADDR_W-1:0] md_issue_rd,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0] md_wd,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd,
    output logic [31:0]       busy_mask,
    output logic              fifo_full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_fifo_rd [DEPTH];
    logic [DATA_W-1:0] r_fifo_wd [DEPTH];
    logic              r_fifo_sq [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_we;
    logic [ADDR_W-1:0] r_a3;
    logic [DATA_W-1:0] r_wd;
    logic [31:0]       r_busy;

    logic              w_pipe_wr;
    logic              w_empty;
    logic              w_ready;
    logic              w_pop;
    logic              w_push;
    logic [ADDR_W-1:0] w_head_rd;
    logic [DATA_W-1:0] w_head_wd;
    logic              w_head_sq;
    logic [31:0]       w_busy_nxt;

    assign w_pipe_wr = pipe_we && (pipe_rd != '0);
    assign w_empty   = (r_count == '0);
    assign w_ready   = (r_count != CNT_W'(DEPTH));
    assign w_pop     = !w_pipe_wr && !w_empty;
    // Results to r0 complete the handshake but are dropped.
    assign w_push    = md_valid && w_ready && (md_rd != '0);
    assign w_head_rd = r_fifo_rd[r_rptr];
    assign w_head_wd = r_fifo_wd[r_rptr];
    assign w_head_sq = r_fifo_sq[r_rptr];

    assign md_ready  = w_ready;
    assign fifo_full = !w_ready;
    assign rf_we     = r_we;
    assign rf_a3     = r_a3;
    assign rf_wd     = r_wd;
    assign busy_mask = r_busy;

    // Next scoreboard: pop clears, issue sets afterwards so set wins; r0 never busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_rd] = 1'b0;
        end
        if (md_issue && (md_issue_rd != '0)) begin
            w_busy_nxt[md_issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Result FIFO storage, pointers and occupancy; pipe writes squash older same-rd entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_rd[i] <= '0;
                r_fifo_wd[i] <= '0;
                r_fifo_sq[i] <= 1'b0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_pipe_wr && (r_fifo_rd[i] == pipe_rd)) begin
                    r_fifo_sq[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_fifo_rd[r_wptr] <= md_rd;
                r_fifo_wd[r_wptr] <= md_wd;
                r_fifo_sq[r_wptr] <= w_pipe_wr && (md_rd == pipe_rd);
                r_wptr            <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered RF write port: pipe first, then unsquashed FIFO head, else idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we <= 1'b0;
            r_a3 <= '0;
            r_wd <= '0;
        end else if (w_pipe_wr) begin
            r_we <= 1'b1;
            r_a3 <= pipe_rd;
            r_wd <= pipe_wd;
        end else if (w_pop && !w_head_sq) begin
            r_we <= 1'b1;
            r_a3 <= w_head_rd;
            r_wd <= w_head_wd;
        end else begin
            r_we <= 1'b0;
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Directed bench for rf_writeback_arb: a per-cycle vector table plus a
// hand-written asynchronous-reset sequence.
module tb_rf_writeback_arb;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_wd;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] busy_mask;
    logic        fifo_full;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        pipe_we;
        logic [4:0]  pipe_rd;
        logic [31:0] pipe_wd;
        logic        md_issue;
        logic [4:0]  md_issue_rd;
        logic        md_valid;
        logic [4:0]  md_rd;
        logic [31:0] md_wd;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
        logic        e_ready;
        logic        e_full;
    } vec_t;

    vec_t vq[$];

    rf_writeback_arb #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wd     (pipe_wd),
        .md_issue    (md_issue),
        .md_issue_rd (md_issue_rd),
        .md_valid    (md_valid),
        .md_ready    (md_ready),
        .md_rd       (md_rd),
        .md_wd       (md_wd),
        .rf_we       (rf_we),
        .rf_a3       (rf_a3),
        .rf_wd       (rf_wd),
        .busy_mask   (busy_mask),
        .fifo_full   (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic pw, input logic [4:0] prd, input logic [31:0] pwd,
                       input logic mi, input logic [4:0] mird,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                       input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
                       input logic [31:0] ebusy, input logic erdy, input logic efull);
        vec_t v;
        v.pipe_we = pw;  v.pipe_rd = prd; v.pipe_wd = pwd;
        v.md_issue = mi; v.md_issue_rd = mird;
        v.md_valid = mv; v.md_rd = mrd; v.md_wd = mwd;
        v.e_we = ewe; v.e_a3 = ea3; v.e_wd = ewd;
        v.e_busy = ebusy; v.e_ready = erdy; v.e_full = efull;
        vq.push_back(v);
    endtask

    task automatic drive_idle();
        pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
        md_issue = 0; md_issue_rd = 0;
        md_valid = 0; md_rd = 0; md_wd = 0;
    endtask

    task automatic check_all(input string tag, input logic ewe, input logic [4:0] ea3,
                             input logic [31:0] ewd, input logic [31:0] ebusy,
                             input logic erdy, input logic efull);
        check({tag, ".rf_we"},     32'(rf_we),     32'(ewe));
        check({tag, ".rf_a3"},     32'(rf_a3),     32'(ea3));
        check({tag, ".rf_wd"},     rf_wd,          ewd);
        check({tag, ".busy_mask"}, busy_mask,      ebusy);
        check({tag, ".md_ready"},  32'(md_ready),  32'(erdy));
        check({tag, ".fifo_full"}, 32'(fifo_full), 32'(efull));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive_idle();
        rst = 1'b1;
        #1;
        check_all("reset", 0, 5'd0, 32'h0, 32'h0, 1, 0);

        //  pw prd  pwd           mi mird  mv mrd   mwd           we a3    wd            busy          rdy full
        add(1, 5'd5,  32'h1234,  0, 5'd0,  0, 5'd0,  32'h0,      1, 5'd5,  32'h1234,    32'h0,        1, 0); // v0
        add(0, 5'd0,  32'h0,     1, 5'd7,  0, 5'd0,  32'h0,      0, 5'd5,  32'h1234,    32'h80,       1, 0); // v1
        add(0, 5'd0,  32'h0,     0, 5'd0,  1, 5'd7,  32'hDEAD,   0, 5'd5,  32'h1234,    32'h80,       1, 0); // v2
        add(0, 5'd0,  32'h0,     0, 5'd0,  0, 5'd0,  32'h0,      1, 5'd7,  32'hDEAD,    32'h0,        1, 0); // v3
        add(1, 5'd1,  32'h11,    1, 5'd10, 1, 5'd10, 32'hA0,     1, 5'd1,  32'h11,      32'h400,      1, 0); // v4
        add(1, 5'd2,  32'h22,    1, 5'd11, 1, 5'd11, 32'hB0,     1, 5'd2,  32'h22,      32'hC00,      0, 1); // v5
        add(1, 5'd3,  32'h33,    0, 5'd0,  1, 5'd12, 32'hC0,     1, 5'd3,  32'h33,      32'hC00,      0, 1); // v6
        add(0, 5'd0,  32'h0,     0, 5'd0,  0, 5'd0,  32'h0,      1, 5'd10, 32'hA0,      32'h800,      1, 0); // v7
        add(0, 5'd0,  32'h0,     0, 5'd0,  0, 5'd0,  32'h0,      1, 5'd11, 32'hB0,      32'h0,        1, 0); // v8
        add(0, 5'd0,  32'h0,     0, 5'd0,  0, 5'd0,  32'h0,      0, 5'd11, 32'hB0,      32'h0,        1, 0); // v9
        add(0, 5'd0,  32'h0,     1, 5'd9,  0, 5'd0,  32'h0,      0, 5'd11, 32'hB0,      32'h200,      1, 0); // v10
        add(1, 5'd4,  32'h44,    0, 5'd0,  1, 5'd9,  32'hAAAA,   1, 5'd4,  32'h44,      32'h200,      1, 0); // v11
        add(1, 5'd9,  32'hBBBB,  0, 5'd0,  0, 5'd0,  32'h0,      1, 5'd9,  32'hBBBB,    32'h200,      1, 0); // v12
        add(0, 5'd0,  32'h0,     0, 5'd0,  0, 5'd0,  32'h0,      0, 5'd9,  32'hBBBB,    32'h0,        1, 0); // v13
        add(0, 5'd0,  32'h0,     1, 5'd6,  0, 5'd0,  32'h0,      0, 5'd9,  32'hBBBB,    32'h40,       1, 0); // v14
        add(1, 5'd6,  32'h66,    0, 5'd0,  1, 5'd6,  32'h6666,   1, 5'd6,  32'h66,      32'h40,       1, 0); // v15
        add(0, 5'd0,  32'h0,     0, 5'd0,  0, 5'd0,  32'h0,      0, 5'd6,  32'h66,      32'h0,        1, 0); // v16
        add(0, 5'd0,  32'h0,     1, 5'd3,  0, 5'd0,  32'h0,      0, 5'd6,  32'h66,      32'h8,        1, 0); // v17
        add(1, 5'd0,  32'hFFFF,  0, 5'd0,  1, 5'd3,  32'h3333,   0, 5'd6,  32'h66,      32'h8,        1, 0); // v18
        add(0, 5'd0,  32'h0,     1, 5'd3,  0, 5'd0,  32'h0,      1, 5'd3,  32'h3333,    32'h8,        1, 0); // v19
        add(1, 5'd0,  32'h7777,  1, 5'd0,  1, 5'd0,  32'h5555,   0, 5'd3,  32'h3333,    32'h8,        1, 0); // v20
        add(0, 5'd0,  32'h0,     0, 5'd0,  0, 5'd0,  32'h0,      0, 5'd3,  32'h3333,    32'h8,        1, 0); // v21
        add(0, 5'd0,  32'h0,     0, 5'd0,  1, 5'd13, 32'hD0,     0, 5'd3,  32'h3333,    32'h8,        1, 0); // v22
        add(1, 5'd0,  32'h9999,  0, 5'd0,  0, 5'd0,  32'h0,      1, 5'd13, 32'hD0,      32'h8,        1, 0); // v23

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("post_reset", 0, 5'd0, 32'h0, 32'h0, 1, 0);

        for (int k = 0; k < vq.size(); k++) begin
            pipe_we     = vq[k].pipe_we;
            pipe_rd     = vq[k].pipe_rd;
            pipe_wd     = vq[k].pipe_wd;
            md_issue    = vq[k].md_issue;
            md_issue_rd = vq[k].md_issue_rd;
            md_valid    = vq[k].md_valid;
            md_rd       = vq[k].md_rd;
            md_wd       = vq[k].md_wd;
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", k), vq[k].e_we, vq[k].e_a3, vq[k].e_wd,
                      vq[k].e_busy, vq[k].e_ready, vq[k].e_full);
        end

        // Queue two results with busy bits set, then reset asynchronously mid-cycle.
        pipe_we = 1; pipe_rd = 5'd1; pipe_wd = 32'h1;
        md_issue = 1; md_issue_rd = 5'd20;
        md_valid = 1; md_rd = 5'd20; md_wd = 32'h20;
        @(posedge clk);
        #1;
        pipe_rd = 5'd2; pipe_wd = 32'h2;
        md_issue_rd = 5'd21;
        md_rd = 5'd21; md_wd = 32'h21;
        @(posedge clk);
        #1;
        check_all("pre_rst", 1, 5'd2, 32'h2, 32'h0030_0008, 0, 1);
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 5'd0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("after_rst%0d", c), 0, 5'd0, 32'h0, 32'h0, 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
